// File: rtl/adc_pkg.sv
// Shared ADC types and constants for the timing and averaging stages.
// Optional peak tracking in this slice is enabled by ADC_PEAK_TRACK_EN.
package adc_pkg;

    localparam int ADC_WIDTH_DFLT   = 12;
    localparam int ADC_FRAME_CYCLES = 81;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        CAPTURE,
        EMIT
    } adc_state_e;

endpackage

// File: rtl/adc_sample_averager_if.sv
// Valid/ready output bundle from the averager to the power stage.
// ADC_PEAK_TRACK_EN adds the window max/min alongside the average.
interface adc_sample_averager_if
    import adc_pkg::*;
#(
    parameter int W = ADC_WIDTH_DFLT
);

    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
`ifdef ADC_PEAK_TRACK_EN
    logic [W-1:0] out_max;
    logic [W-1:0] out_min;
`endif

    modport master (
        output out_data,
        output out_valid,
`ifdef ADC_PEAK_TRACK_EN
        output out_max,
        output out_min,
`endif
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
`ifdef ADC_PEAK_TRACK_EN
        input  out_max,
        input  out_min,
`endif
        output out_ready
    );

endinterface

// File: rtl/adc_strobe_detect.sv
// Falling-edge detector on the active-low conversion-start strobe.
// History resets high so a strobe held low through reset fires once.
module adc_strobe_detect (
    input  logic clock_in,
    input  logic reset_n,
    input  logic adc_reset_n,
    output logic start
);

    logic adc_reset_n_d;

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) adc_reset_n_d <= 1'b1;
        else          adc_reset_n_d <= adc_reset_n;
    end

    assign start = adc_reset_n_d & ~adc_reset_n;

endmodule

// File: rtl/adc_sample_averager.sv
// Captures ADC results after each strobe and emits the truncated mean.
// Define ADC_PEAK_TRACK_EN to also report the window max/min.
module adc_sample_averager
    import adc_pkg::*;
#(
    parameter int ADC_WIDTH   = ADC_WIDTH_DFLT,
    parameter int AVG_LOG2    = 4,
    parameter int CONV_CYCLES = 40
) (
    input  logic                 clock_in,
    input  logic                 reset_n,
    input  logic                 adc_reset_n,
    input  logic [ADC_WIDTH-1:0] adc_data,
    input  logic                 ovr_clear,
    output logic                 strobe_miss,
    output logic                 avg_drop,
    adc_sample_averager_if.master out_if
);

    localparam int ACC_W = ADC_WIDTH + AVG_LOG2;
    localparam int CNT_W = $clog2(CONV_CYCLES + 1);

    adc_state_e           state;
    logic [CNT_W-1:0]     conv_cnt;
    logic [AVG_LOG2-1:0]  sample_cnt;
    logic [ACC_W-1:0]     acc;
    logic [ADC_WIDTH-1:0] avg;
    logic                 start;
    logic                 xfer;
`ifdef ADC_PEAK_TRACK_EN
    logic [ADC_WIDTH-1:0] pk_max;
    logic [ADC_WIDTH-1:0] pk_min;
`endif

    adc_strobe_detect u_det (
        .clock_in    (clock_in),
        .reset_n     (reset_n),
        .adc_reset_n (adc_reset_n),
        .start       (start)
    );

    assign avg  = acc[ACC_W-1:AVG_LOG2];
    assign xfer = out_if.out_valid && out_if.out_ready;

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            conv_cnt         <= '0;
            sample_cnt       <= '0;
            acc              <= '0;
            out_if.out_data  <= '0;
            out_if.out_valid <= 1'b0;
            strobe_miss      <= 1'b0;
            avg_drop         <= 1'b0;
`ifdef ADC_PEAK_TRACK_EN
            pk_max           <= '0;
            pk_min           <= '1;
            out_if.out_max   <= '0;
            out_if.out_min   <= '0;
`endif
        end else begin
            if (xfer) out_if.out_valid <= 1'b0;
            // Clear first so a same-cycle set takes priority.
            if (ovr_clear) begin
                strobe_miss <= 1'b0;
                avg_drop    <= 1'b0;
            end
            if (start && state != IDLE) strobe_miss <= 1'b1;

            unique case (state)
                IDLE: begin
                    if (start) begin
                        conv_cnt <= CNT_W'(CONV_CYCLES - 1);
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (conv_cnt == '0) state <= CAPTURE;
                    else conv_cnt <= conv_cnt - 1'b1;
                end
                CAPTURE: begin
                    acc        <= acc + ACC_W'(adc_data);
                    sample_cnt <= sample_cnt + 1'b1;
                    state      <= (&sample_cnt) ? EMIT : IDLE;
`ifdef ADC_PEAK_TRACK_EN
                    if (adc_data > pk_max) pk_max <= adc_data;
                    if (adc_data < pk_min) pk_min <= adc_data;
`endif
                end
                EMIT: begin
                    if (!out_if.out_valid || out_if.out_ready) begin
                        out_if.out_data  <= avg;
                        out_if.out_valid <= 1'b1;
`ifdef ADC_PEAK_TRACK_EN
                        out_if.out_max   <= pk_max;
                        out_if.out_min   <= pk_min;
`endif
                    end else begin
                        avg_drop <= 1'b1;
                    end
                    acc        <= '0;
                    sample_cnt <= '0;
`ifdef ADC_PEAK_TRACK_EN
                    pk_max     <= '0;
                    pk_min     <= '1;
`endif
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_sample_averager.sv
// Scoreboard bench for adc_sample_averager with a framed strobe source.
// Peak outputs are checked when ADC_PEAK_TRACK_EN is defined.
module tb_adc_sample_averager;
    import adc_pkg::*;

    localparam int W   = 12;
    localparam int CAP = 41;
    localparam int N   = 16;

    logic         clock_in    = 1'b0;
    logic         reset_n     = 1'b0;
    logic         adc_reset_n = 1'b1;
    logic         ovr_clear   = 1'b0;
    logic [W-1:0] adc_data    = '0;
    logic         strobe_miss;
    logic         avg_drop;

    adc_sample_averager_if #(.W(W)) out_if ();

    adc_sample_averager dut (
        .clock_in    (clock_in),
        .reset_n     (reset_n),
        .adc_reset_n (adc_reset_n),
        .adc_data    (adc_data),
        .ovr_clear   (ovr_clear),
        .strobe_miss (strobe_miss),
        .avg_drop    (avg_drop),
        .out_if      (out_if)
    );

    always #10 clock_in = ~clock_in;

    typedef struct packed {
        logic [W-1:0] avg;
        logic [W-1:0] mx;
        logic [W-1:0] mn;
    } exp_t;

    exp_t   sb[$];
    int     n_vec = 0;
    int     n_err = 0;
    int     n_xfer = 0;
    longint cyc = 0;
    longint prev_xfer = 0;
    longint last_xfer = 0;

    always @(posedge clock_in) cyc++;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clock_in) begin
        if (reset_n && out_if.out_valid && out_if.out_ready) begin
            exp_t e;
            prev_xfer = last_xfer;
            last_xfer = cyc;
            n_xfer++;
            if (sb.size() == 0) begin
                check("sb_level", 32'(sb.size()), 1);
            end else begin
                e = sb.pop_front();
                check("avg", 32'(out_if.out_data), 32'(e.avg));
`ifdef ADC_PEAK_TRACK_EN
                check("max", 32'(out_if.out_max), 32'(e.mx));
                check("min", 32'(out_if.out_min), 32'(e.mn));
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clock_in);
        #1;
    endtask

    // One 81-clock frame; data is only valid in the capture cycle.
    task automatic strobe(input logic [W-1:0] val, input bit extra);
        for (int c = 0; c < ADC_FRAME_CYCLES; c++) begin
            adc_reset_n = !(c == 0 || (extra && c == 10));
            adc_data    = (c == CAP) ? val : ~val;
            tick();
        end
    endtask

    task automatic window(input logic [W-1:0] base,
                          input logic [W-1:0] step,
                          input bit push,
                          input bit extra);
        int   sum = 0;
        exp_t e;
        e.mx = '0;
        e.mn = '1;
        for (int i = 0; i < N; i++) begin
            logic [W-1:0] v;
            v = base + W'(i) * step;
            sum += int'(v);
            if (v > e.mx) e.mx = v;
            if (v < e.mn) e.mn = v;
        end
        e.avg = W'(sum / N);
        if (push) sb.push_back(e);
        for (int i = 0; i < N; i++)
            strobe(base + W'(i) * step, extra && i == 0);
    endtask

    initial begin
        int n0;
        out_if.out_ready = 1'b1;
        repeat (3) tick();
        check("rst_valid", 32'(out_if.out_valid), 0);
        check("rst_data", 32'(out_if.out_data), 0);
        check("rst_miss", 32'(strobe_miss), 0);
        check("rst_drop", 32'(avg_drop), 0);
        reset_n = 1'b1;
        tick();

        window(12'h400, 0, 1, 0);
        window(12'h400, 0, 1, 0);
        check("period", 32'(last_xfer - prev_xfer), 1296);

        window(12'h000, 1, 1, 0);
        window(12'hFFF, 0, 1, 0);
        window(12'h005, 1, 1, 0);

        out_if.out_ready = 1'b0;
        window(12'h123, 0, 1, 0);
        window(12'h456, 0, 0, 0);
        check("hold_valid", 32'(out_if.out_valid), 1);
        check("hold_data", 32'(out_if.out_data), 32'h123);
        check("drop_set", 32'(avg_drop), 1);
        check("no_miss", 32'(strobe_miss), 0);
        ovr_clear = 1'b1;
        tick();
        ovr_clear = 1'b0;
        check("drop_clr", 32'(avg_drop), 0);
        check("held_data", 32'(out_if.out_data), 32'h123);
        out_if.out_ready = 1'b1;
        tick();
        tick();
        check("drained", 32'(out_if.out_valid), 0);

        window(12'h100, 0, 1, 1);
        check("miss_set", 32'(strobe_miss), 1);
        check("miss_nodrop", 32'(avg_drop), 0);
        ovr_clear = 1'b1;
        tick();
        ovr_clear = 1'b0;
        check("miss_clr", 32'(strobe_miss), 0);

        for (int i = 0; i < 7; i++) strobe(12'hFFF, 0);
        adc_reset_n = 1'b1;
        reset_n = 1'b0;
        repeat (3) tick();
        check("mid_rst_valid", 32'(out_if.out_valid), 0);
        reset_n = 1'b1;
        tick();
        n0 = n_xfer;
        sb.push_back('{avg: 12'h010, mx: 12'h010, mn: 12'h010});
        for (int i = 0; i < N - 1; i++) strobe(12'h010, 0);
        check("early_out", 32'(n_xfer), 32'(n0));
        strobe(12'h010, 0);
        check("rst_out", 32'(n_xfer), 32'(n0 + 1));

        check("sb_drain", 32'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
